// File: rtl/conv_sequencer.sv
// conv_sequencer: central scheduler for the P-lane convolution datapath.
// Once a full input frame sits in the x buffer, it walks the filter taps
// for one batch of P outputs at a time. For each batch it drives the x/filter
// read addresses, the MAC accumulate enable and clear, and the result
// handshake towards the output buffer.
// Every output is a register. Most outputs are loaded from the next-state
// values, so they line up with the state they describe.
module conv_sequencer #(
   parameter int LENX  = 64,
   parameter int LENF  = 33,
   parameter int P     = 2,
   parameter int ADDRX = 6,
   parameter int ADDRF = 6
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 x_loaded,
   input  logic                 out_ready,
   output logic [P*ADDRX-1:0]   addr_x,
   output logic [ADDRF-1:0]     addr_f,
   output logic                 en_acc,
   output logic                 clr_acc,
   output logic                 res_valid,
   output logic [ADDRX-1:0]     res_base,
   output logic [P-1:0]         res_mask,
   output logic                 frame_done,
   output logic                 busy
);

   // Outputs produced by one frame.
   localparam int NOUT = LENX - LENF + 1;
   // Batch base counter is one bit wider than an x address so it never wraps.
   localparam int NW   = ADDRX + 1;
   // Working width for address sums: base + lane + tap cannot overflow this.
   localparam int SW   = ((ADDRX > ADDRF) ? ADDRX : ADDRF) + 2;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_DRAIN,
      S_WRITE,
      S_CLEAR,
      S_DONE
   } state_t;

   state_t             state_reg, state_next;
   logic [ADDRF-1:0]   k_reg, k_next;
   logic [NW-1:0]      n_reg, n_next;

   logic               last_batch;
   logic [P*ADDRX-1:0] addr_x_next;
   logic [P-1:0]       mask_next;

   // The batch just written is the last one once the next base would pass NOUT.
   assign last_batch = (SW'(n_reg) + SW'(P)) >= SW'(NOUT);

   // Per-lane read address and mask, computed from the counters being loaded.
   // Lanes past the end of the frame clamp to the last x sample. Those lanes
   // are masked off in the result, so the clamped data is never used.
   generate
      for (genvar gi = 0; gi < P; gi++) begin : gen_lane
         logic [SW-1:0] lane_base;
         logic [SW-1:0] lane_sum;

         assign lane_base = SW'(n_next) + SW'(gi);
         assign lane_sum  = lane_base + SW'(k_next);

         assign addr_x_next[gi*ADDRX +: ADDRX] =
            (lane_sum > SW'(LENX - 1)) ? ADDRX'(LENX - 1) : lane_sum[ADDRX-1:0];
         assign mask_next[gi] = lane_base < SW'(NOUT);
      end
   endgenerate

   // Next-state and counter logic.
   always_comb begin
      state_next = state_reg;
      k_next     = k_reg;
      n_next     = n_reg;
      case (state_reg)
         S_IDLE: begin
            if (x_loaded) begin
               n_next     = '0;
               k_next     = '0;
               state_next = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (k_reg == ADDRF'(LENF - 1)) begin
               state_next = S_DRAIN;
            end else begin
               k_next = k_reg + ADDRF'(1);
            end
         end
         S_DRAIN: begin
            state_next = S_WRITE;
         end
         S_WRITE: begin
            if (out_ready) begin
               if (last_batch) begin
                  state_next = S_DONE;
               end else begin
                  n_next     = n_reg + NW'(P);
                  k_next     = '0;
                  state_next = S_CLEAR;
               end
            end
         end
         S_CLEAR: begin
            state_next = S_ISSUE;
         end
         S_DONE: begin
            state_next = S_IDLE;
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   // State and counter registers.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_reg <= S_IDLE;
         k_reg     <= '0;
         n_reg     <= '0;
      end else begin
         state_reg <= state_next;
         k_reg     <= k_next;
         n_reg     <= n_next;
      end
   end

   // Read addresses advance only while issuing. They hold through DRAIN,
   // so the final tap's data is still addressed while it accumulates.
   always_ff @(posedge clk) begin
      if (!reset) begin
         addr_x <= '0;
         addr_f <= '0;
      end else if (state_next == S_ISSUE) begin
         addr_x <= addr_x_next;
         addr_f <= k_next;
      end
   end

   // Accumulator control. Enable trails ISSUE by one cycle to match the
   // buffer/ROM read latency. Clear is asserted in every state that sits
   // between batches.
   always_ff @(posedge clk) begin
      if (!reset) begin
         en_acc  <= 1'b0;
         clr_acc <= 1'b1;
      end else begin
         en_acc  <= (state_reg == S_ISSUE);
         clr_acc <= (state_next == S_IDLE) || (state_next == S_CLEAR) ||
                    (state_next == S_DONE);
      end
   end

   // Result handshake. Base and mask are captured on entry to WRITE and
   // hold until the next batch.
   always_ff @(posedge clk) begin
      if (!reset) begin
         res_valid <= 1'b0;
         res_base  <= '0;
         res_mask  <= '0;
      end else begin
         res_valid <= (state_next == S_WRITE);
         if ((state_next == S_WRITE) && (state_reg != S_WRITE)) begin
            res_base <= n_next[ADDRX-1:0];
            res_mask <= mask_next;
         end
      end
   end

   // Frame status: a single-cycle done pulse, and busy outside IDLE.
   always_ff @(posedge clk) begin
      if (!reset) begin
         frame_done <= 1'b0;
         busy       <= 1'b0;
      end else begin
         frame_done <= (state_next == S_DONE);
         busy       <= (state_next != S_IDLE);
      end
   end

endmodule

// File: tb/tb_conv_sequencer.sv
// tb_conv_sequencer: directed checks of conv_sequencer.
// DUT a uses the default geometry. DUT b uses LENX=9, LENF=4, P=4.
module tb_conv_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- DUT a: defaults ----------------
   logic        reset_a, xl_a, or_a;
   logic [11:0] addr_x_a;
   logic [5:0]  addr_f_a;
   logic        en_a, clr_a, v_a, done_a, busy_a;
   logic [5:0]  base_a;
   logic [1:0]  mask_a;

   conv_sequencer dut_a (
      .clk        (clk),
      .reset      (reset_a),
      .x_loaded   (xl_a),
      .out_ready  (or_a),
      .addr_x     (addr_x_a),
      .addr_f     (addr_f_a),
      .en_acc     (en_a),
      .clr_acc    (clr_a),
      .res_valid  (v_a),
      .res_base   (base_a),
      .res_mask   (mask_a),
      .frame_done (done_a),
      .busy       (busy_a)
   );

   // ---------------- DUT b: LENX=9 LENF=4 P=4 ----------------
   logic        reset_b, xl_b, or_b;
   logic [15:0] addr_x_b;
   logic [1:0]  addr_f_b;
   logic        en_b, clr_b, v_b, done_b, busy_b;
   logic [3:0]  base_b;
   logic [3:0]  mask_b;

   conv_sequencer #(.LENX(9), .LENF(4), .P(4), .ADDRX(4), .ADDRF(2)) dut_b (
      .clk        (clk),
      .reset      (reset_b),
      .x_loaded   (xl_b),
      .out_ready  (or_b),
      .addr_x     (addr_x_b),
      .addr_f     (addr_f_b),
      .en_acc     (en_b),
      .clr_acc    (clr_b),
      .res_valid  (v_b),
      .res_base   (base_b),
      .res_mask   (mask_b),
      .frame_done (done_b),
      .busy       (busy_b)
   );

   int n_pass  = 0;
   int n_total = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp)
         $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
      else
         n_pass++;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_a(input string tag);
      chk({tag, "_addr_x"}, 32'(addr_x_a), 32'd0);
      chk({tag, "_addr_f"}, 32'(addr_f_a), 32'd0);
      chk({tag, "_en"},     32'(en_a),     32'd0);
      chk({tag, "_clr"},    32'(clr_a),    32'd1);
      chk({tag, "_valid"},  32'(v_a),      32'd0);
      chk({tag, "_base"},   32'(base_a),   32'd0);
      chk({tag, "_mask"},   32'(mask_a),   32'd0);
      chk({tag, "_done"},   32'(done_a),   32'd0);
      chk({tag, "_busy"},   32'(busy_a),   32'd0);
   endtask

   // One table row per clock edge on DUT b. The inputs apply before the
   // edge; the expectations hold after it. Addresses are compared when ca=1,
   // base/mask when v=1.
   typedef struct {
      logic        xl;
      logic        ordy;
      logic        ca;
      logic [15:0] ax;
      logic [1:0]  af;
      logic        en;
      logic        clr;
      logic        v;
      logic [3:0]  base;
      logic [3:0]  mask;
      logic        done;
      logic        busy;
   } vec_t;

   vec_t tbl [19];

   // Stops the run if something stalls; normal completion is far earlier.
   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete, expected finish");
      $fatal(1);
   end

   initial begin
      int b, o, oo, nvalid, ndone, lat, w;

      //            xl    or    ca    ax        af    en    clr   v     base  mask     done  busy
      tbl[0]  = '{1'b1, 1'b1, 1'b1, 16'h3210, 2'd0, 1'b0, 1'b0, 1'b0, 4'd0, 4'h0, 1'b0, 1'b1};
      tbl[1]  = '{1'b1, 1'b1, 1'b1, 16'h4321, 2'd1, 1'b1, 1'b0, 1'b0, 4'd0, 4'h0, 1'b0, 1'b1};
      tbl[2]  = '{1'b1, 1'b1, 1'b1, 16'h5432, 2'd2, 1'b1, 1'b0, 1'b0, 4'd0, 4'h0, 1'b0, 1'b1};
      tbl[3]  = '{1'b1, 1'b1, 1'b1, 16'h6543, 2'd3, 1'b1, 1'b0, 1'b0, 4'd0, 4'h0, 1'b0, 1'b1};
      tbl[4]  = '{1'b1, 1'b1, 1'b1, 16'h6543, 2'd3, 1'b1, 1'b0, 1'b0, 4'd0, 4'h0, 1'b0, 1'b1};
      tbl[5]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 2'd0, 1'b0, 1'b0, 1'b1, 4'd0, 4'hF, 1'b0, 1'b1};
      tbl[6]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 2'd0, 1'b0, 1'b0, 1'b1, 4'd0, 4'hF, 1'b0, 1'b1};
      tbl[7]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 2'd0, 1'b0, 1'b0, 1'b1, 4'd0, 4'hF, 1'b0, 1'b1};
      tbl[8]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 2'd0, 1'b0, 1'b1, 1'b0, 4'd0, 4'h0, 1'b0, 1'b1};
      tbl[9]  = '{1'b1, 1'b1, 1'b1, 16'h7654, 2'd0, 1'b0, 1'b0, 1'b0, 4'd0, 4'h0, 1'b0, 1'b1};
      tbl[10] = '{1'b1, 1'b1, 1'b1, 16'h8765, 2'd1, 1'b1, 1'b0, 1'b0, 4'd0, 4'h0, 1'b0, 1'b1};
      tbl[11] = '{1'b1, 1'b1, 1'b1, 16'h8876, 2'd2, 1'b1, 1'b0, 1'b0, 4'd0, 4'h0, 1'b0, 1'b1};
      tbl[12] = '{1'b1, 1'b1, 1'b1, 16'h8887, 2'd3, 1'b1, 1'b0, 1'b0, 4'd0, 4'h0, 1'b0, 1'b1};
      tbl[13] = '{1'b1, 1'b1, 1'b1, 16'h8887, 2'd3, 1'b1, 1'b0, 1'b0, 4'd0, 4'h0, 1'b0, 1'b1};
      tbl[14] = '{1'b1, 1'b1, 1'b0, 16'h0000, 2'd0, 1'b0, 1'b0, 1'b1, 4'd4, 4'h3, 1'b0, 1'b1};
      tbl[15] = '{1'b1, 1'b1, 1'b0, 16'h0000, 2'd0, 1'b0, 1'b1, 1'b0, 4'd0, 4'h0, 1'b1, 1'b1};
      tbl[16] = '{1'b1, 1'b1, 1'b0, 16'h0000, 2'd0, 1'b0, 1'b1, 1'b0, 4'd0, 4'h0, 1'b0, 1'b0};
      tbl[17] = '{1'b0, 1'b1, 1'b0, 16'h0000, 2'd0, 1'b0, 1'b1, 1'b0, 4'd0, 4'h0, 1'b0, 1'b0};
      tbl[18] = '{1'b1, 1'b1, 1'b1, 16'h3210, 2'd0, 1'b0, 1'b0, 1'b0, 4'd0, 4'h0, 1'b0, 1'b1};

      reset_a = 1'b0; xl_a = 1'b0; or_a = 1'b0;
      reset_b = 1'b0; xl_b = 1'b0; or_b = 1'b0;
      repeat (3) step();

      // Reset values.
      chk_reset_a("rst");
      chk("rst_b_clr",  32'(clr_b),  32'd1);
      chk("rst_b_busy", 32'(busy_b), 32'd0);
      chk("rst_b_addr", 32'(addr_x_b), 32'd0);
      $display("reset: values checked");

      reset_a = 1'b1; reset_b = 1'b1;
      step();

      // Table: small geometry, WRITE stall, partial clamped batch, restart.
      for (int e = 0; e < 19; e++) begin
         xl_b = tbl[e].xl;
         or_b = tbl[e].ordy;
         step();
         chk($sformatf("tbl%0d_en", e),   32'(en_b),   32'(tbl[e].en));
         chk($sformatf("tbl%0d_clr", e),  32'(clr_b),  32'(tbl[e].clr));
         chk($sformatf("tbl%0d_v", e),    32'(v_b),    32'(tbl[e].v));
         chk($sformatf("tbl%0d_done", e), 32'(done_b), 32'(tbl[e].done));
         chk($sformatf("tbl%0d_busy", e), 32'(busy_b), 32'(tbl[e].busy));
         if (tbl[e].ca) begin
            chk($sformatf("tbl%0d_ax", e), 32'(addr_x_b), 32'(tbl[e].ax));
            chk($sformatf("tbl%0d_af", e), 32'(addr_f_b), 32'(tbl[e].af));
         end
         if (tbl[e].v) begin
            chk($sformatf("tbl%0d_base", e), 32'(base_b), 32'(tbl[e].base));
            chk($sformatf("tbl%0d_mask", e), 32'(mask_b), 32'(tbl[e].mask));
         end
         $display("tbl %0d: xl=%0b or=%0b ax=%h af=%0d en=%0b clr=%0b v=%0b base=%0d mask=%h done=%0b busy=%0b",
                  e, xl_b, or_b, addr_x_b, addr_f_b, en_b, clr_b, v_b, base_b, mask_b, done_b, busy_b);
      end
      xl_b = 1'b0;

      // Full default frame with out_ready held high: 16 batches of 36 cycles.
      or_a = 1'b1; xl_a = 1'b1;
      nvalid = 0; ndone = 0;
      for (int c = 0; c < 578; c++) begin
         if (c == 576) xl_a = 1'b0;
         step();
         if (c < 576) begin
            b = c / 36;
            o = c % 36;
            chk("f1_busy",  32'(busy_a), 32'd1);
            chk("f1_valid", 32'(v_a),    32'(o == 34));
            chk("f1_en",    32'(en_a),   32'(o >= 1 && o <= 33));
            chk("f1_clr",   32'(clr_a),  32'(o == 35));
            chk("f1_done",  32'(done_a), 32'(b == 15 && o == 35));
            if (o <= 33) begin
               oo = (o > 32) ? 32 : o;
               chk("f1_addr_f", 32'(addr_f_a), 32'(oo));
               for (int i = 0; i < 2; i++)
                  chk("f1_addr_x", 32'(addr_x_a[i*6 +: 6]), 32'(2*b + i + oo));
            end
            if (o == 34) begin
               chk("f1_base", 32'(base_a), 32'(2*b));
               chk("f1_mask", 32'(mask_a), 32'd3);
               $display("frame1 batch: base=%0d mask=%0b", base_a, mask_a);
            end
         end else begin
            chk("f1_idle_busy",  32'(busy_a), 32'd0);
            chk("f1_idle_clr",   32'(clr_a),  32'd1);
            chk("f1_idle_valid", 32'(v_a),    32'd0);
            chk("f1_idle_done",  32'(done_a), 32'd0);
         end
         if (v_a)    nvalid++;
         if (done_a) ndone++;
      end
      chk("f1_batches", 32'(nvalid), 32'd16);
      chk("f1_done_pulses", 32'(ndone), 32'd1);
      $display("frame1: batches=%0d frame_done pulses=%0d", nvalid, ndone);

      // WRITE stall: out_ready low for 10 WRITE cycles.
      or_a = 1'b0; xl_a = 1'b1;
      for (int c = 0; c < 45; c++) begin
         step();
         if (c >= 34) begin
            chk("stall_valid", 32'(v_a),    32'd1);
            chk("stall_base",  32'(base_a), 32'd0);
            chk("stall_mask",  32'(mask_a), 32'd3);
            chk("stall_en",    32'(en_a),   32'd0);
            chk("stall_clr",   32'(clr_a),  32'd0);
         end
      end
      or_a = 1'b1;
      step();
      chk("stall_rel_valid", 32'(v_a),   32'd0);
      chk("stall_rel_clr",   32'(clr_a), 32'd1);
      chk("stall_rel_en",    32'(en_a),  32'd0);
      step();
      chk("stall_issue_clr", 32'(clr_a),    32'd0);
      chk("stall_issue_af",  32'(addr_f_a), 32'd0);
      chk("stall_issue_x0",  32'(addr_x_a[5:0]),  32'd2);
      chk("stall_issue_x1",  32'(addr_x_a[11:6]), 32'd3);
      $display("stall: released, CLEAR then ISSUE base 2");

      // Reset in the middle of ISSUE for the third batch (n=4, k=5).
      for (int c = 47; c < 88; c++) step();
      chk("pre_rst_af", 32'(addr_f_a),       32'd5);
      chk("pre_rst_x0", 32'(addr_x_a[5:0]),  32'd9);
      reset_a = 1'b0;
      step();
      chk_reset_a("midrst");
      step();
      chk_reset_a("midrst_hold");
      reset_a = 1'b1;
      step();
      chk("restart_busy", 32'(busy_a),          32'd1);
      chk("restart_af",   32'(addr_f_a),        32'd0);
      chk("restart_x0",   32'(addr_x_a[5:0]),   32'd0);
      chk("restart_x1",   32'(addr_x_a[11:6]),  32'd1);
      lat = 0;
      while (!v_a && lat < 100) begin step(); lat++; end
      chk("restart_latency", 32'(lat),    32'd34);
      chk("restart_base",    32'(base_a), 32'd0);
      chk("restart_mask",    32'(mask_a), 32'd3);
      $display("reset mid-frame: restart latency=%0d base=%0d", lat, base_a);

      // Back-to-back frames: x_loaded stale for one edge, low two, then high.
      w = 0;
      while (!done_a && w < 700) begin step(); w++; end
      chk("b2b_done_seen", 32'(done_a), 32'd1);
      step();
      chk("b2b_idle1_busy", 32'(busy_a), 32'd0);
      chk("b2b_idle1_done", 32'(done_a), 32'd0);
      xl_a = 1'b0;
      step();
      chk("b2b_idle2_busy", 32'(busy_a), 32'd0);
      step();
      chk("b2b_idle3_busy", 32'(busy_a), 32'd0);
      xl_a = 1'b1;
      step();
      chk("b2b_start_busy", 32'(busy_a),         32'd1);
      chk("b2b_start_af",   32'(addr_f_a),       32'd0);
      chk("b2b_start_x0",   32'(addr_x_a[5:0]),  32'd0);
      chk("b2b_start_x1",   32'(addr_x_a[11:6]), 32'd1);
      lat = 0;
      while (!v_a && lat < 100) begin step(); lat++; end
      chk("b2b_latency", 32'(lat),    32'd34);
      chk("b2b_base",    32'(base_a), 32'd0);
      $display("back-to-back: second frame latency=%0d base=%0d", lat, base_a);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/conv_sequencer.md
Name: conv_sequencer

Overview:
- Central scheduler for the P-lane parallel convolution datapath: x buffer (P read ports), filter ROM, P MAC accumulators, output buffer.
- Once a full input frame is loaded, it generates x/f read addresses, accumulator enable/clear, and batched result handshakes, one pass of P outputs at a time.
- It replaces the ad-hoc conv/output control logic with one explicit FSM.
- It sits between the input memory controller (x_loaded / frame_done) and the output buffer (res_valid / out_ready).

Parameters:
- LENX, 64, input vector length.
- LENF, 33, filter length.
- P, 2, number of parallel MAC lanes.
- ADDRX, 6, x address width (≥ clog2(LENX)).
- ADDRF, 6, filter address width (≥ clog2(LENF)).
- NOUT (derived), LENX-LENF+1 = 32, outputs per frame.

Ports:
- clk  input  1  clock, all logic on rising edge.
- reset  input  1  synchronous, active-low (reset==0 resets on the clock edge).
- x_loaded  input  1  level: full frame resident in x buffer.
- out_ready  input  1  output buffer can accept one P-wide result batch this cycle.
- addr_x  output  P*ADDRX  lane i read address at bits [i*ADDRX +: ADDRX].
- addr_f  output  ADDRF  filter ROM read address, shared by all lanes.
- en_acc  output  1  MAC accumulate enable.
- clr_acc  output  1  MAC accumulator clear.
- res_valid  output  1  lane accumulators hold a completed batch.
- res_base  output  ADDRX  output index of lane 0 of the current batch.
- res_mask  output  P  bit i=1 iff res_base+i < NOUT.
- frame_done  output  1  one-cycle pulse, last batch accepted.
- busy  output  1  high in every state except IDLE.

Behaviour:
- All outputs are registered.
- Reset values:
  - state=IDLE.
  - addr_x all lanes 0, addr_f=0.
  - en_acc=0, clr_acc=1.
  - res_valid=0, res_base=0, res_mask=0.
  - frame_done=0, busy=0.
- Reset mid-operation: abandon the frame and return to IDLE with the above values on the next edge. No partial batch or frame_done is emitted.
- Counters:
  - k: tap index, 0..LENF-1.
  - n: batch base, steps 0, P, 2P, ...; width ADDRX+1 so it never wraps.
- IDLE:
  - clr_acc=1, en_acc=0.
  - On x_loaded=1: n<=0, k<=0, go to ISSUE.
- ISSUE (exactly LENF cycles):
  - addr_f=k.
  - addr_x[i]=n+i+k, clamped to LENX-1 when it exceeds LENX-1 (masked lanes only).
  - clr_acc=0.
  - k increments each cycle; at k==LENF-1 go to DRAIN.
- en_acc equals "state was ISSUE" delayed one cycle, matching the one-cycle memory/ROM read latency.
  - en_acc is therefore high for exactly LENF consecutive cycles: from ISSUE cycle 2 through the DRAIN cycle.
- DRAIN (1 cycle): final product accumulates; addresses hold. Go to WRITE.
- WRITE:
  - res_valid=1; res_base=n; res_mask per definition.
  - en_acc=0, clr_acc=0; hold until out_ready=1.
  - Handshake: the edge where res_valid=1 and out_ready=1.
  - On handshake with n+P >= NOUT: go to DONE. Otherwise n<=n+P, k<=0, go to CLEAR.
  - res_valid drops the cycle after the handshake.
- CLEAR (1 cycle): clr_acc=1, en_acc=0. Go to ISSUE.
- DONE (1 cycle): frame_done=1, clr_acc=1. Go to IDLE.
  - The input controller must deassert x_loaded on the edge after frame_done, so IDLE sees x_loaded=0 and does not restart on the stale frame.
  - If x_loaded is high again in IDLE (next frame already loaded), start immediately.
- out_ready outside WRITE is ignored. x_loaded outside IDLE is ignored.
- Latency: first res_valid is LENF+2 cycles after the IDLE edge that samples x_loaded=1. Per-batch period is LENF+3 cycles plus WRITE stall cycles.
- Passes per frame: ceil(NOUT/P). The final batch may be partial (res_mask).

Test Plan:
- Defaults, out_ready held 1, x_loaded asserted at cycle t:
  - ISSUE at t+1..t+33; en_acc high t+2..t+34; res_valid at t+35 with res_base=0, mask=2'b11.
  - 16 batches total, res_base 0,2,...,30; single frame_done; busy low after.
- Address check, defaults, batch n=4: addr_x lanes cycle (4,5),(5,6),...,(36,37); addr_f 0..32; no clamp.
- LENX=9, LENF=4, P=4 (NOUT=6):
  - Batches res_base=0 mask=4'b1111, then res_base=4 mask=4'b0011.
  - Lanes 2,3 of the second batch clamp addr_x to 8.
- out_ready=0 for 10 cycles in WRITE: res_valid, res_base, mask held stable, en_acc=0, accumulators not cleared. Release -> CLEAR pulse, then ISSUE.
- reset=0 during ISSUE of batch 3: next edge all outputs at reset values. After release with x_loaded=1, the sequence restarts at res_base=0.
- Back-to-back frames: x_loaded drops one cycle after frame_done and reasserts 2 cycles later -> second frame starts cleanly; no spurious restart on the stale x_loaded.
